// File: rtl/multicycle_control_unit.sv
// Main FSM and decode for the multicycle ARM-subset datapath.
// Moore outputs per state, gated by the condition check against the NZCV register.
module multicycle_control_unit #(
   parameter logic [3:0] FLAGS_RESET = 4'b0000
) (
   input  logic       clk,
   input  logic       reset,
   input  logic [3:0] cond,
   input  logic [1:0] op,
   input  logic [5:0] funct,
   input  logic [3:0] rd,
   input  logic [3:0] alu_flags,
   output logic       pc_write,
   output logic       adr_src,
   output logic       mem_write,
   output logic       ir_write,
   output logic       reg_write,
   output logic [1:0] result_src,
   output logic       alu_src_a,
   output logic [1:0] alu_src_b,
   output logic [1:0] alu_control,
   output logic [1:0] imm_src,
   output logic [1:0] reg_src,
   output logic [3:0] flags
);

   typedef enum logic [3:0] {
      S_FETCH, S_DECODE, S_MEM_ADR, S_MEM_READ, S_MEM_WB,
      S_MEM_WRITE, S_EXEC_R, S_EXEC_I, S_ALU_WB, S_BRANCH
   } state_t;

   state_t     state, state_next;
   logic [3:0] flags_q;
   logic       reg_w, mem_w, next_pc, branch, alu_op;
   logic       cond_ex;
   logic       cmd_known, cmd_arith;
   logic       flags_we;

   assign flags   = flags_q;
   assign imm_src = op;
   assign reg_src = {op == 2'b01, op == 2'b10};

   always_ff @(posedge clk) begin
      if (reset) begin
         state   <= S_FETCH;
         flags_q <= FLAGS_RESET;
      end else begin
         state <= state_next;
         if (flags_we) begin
            flags_q[3:2] <= alu_flags[3:2];
            if (cmd_arith) flags_q[1:0] <= alu_flags[1:0];
         end
      end
   end

   // ARM condition evaluation against the registered NZCV
   always_comb begin
      cond_ex = 1'b0;
      case (cond)
         4'b0000: cond_ex = flags_q[2];
         4'b0001: cond_ex = ~flags_q[2];
         4'b0010: cond_ex = flags_q[1];
         4'b0011: cond_ex = ~flags_q[1];
         4'b0100: cond_ex = flags_q[3];
         4'b0101: cond_ex = ~flags_q[3];
         4'b0110: cond_ex = flags_q[0];
         4'b0111: cond_ex = ~flags_q[0];
         4'b1000: cond_ex = flags_q[1] & ~flags_q[2];
         4'b1001: cond_ex = ~flags_q[1] | flags_q[2];
         4'b1010: cond_ex = (flags_q[3] == flags_q[0]);
         4'b1011: cond_ex = (flags_q[3] != flags_q[0]);
         4'b1100: cond_ex = ~flags_q[2] & (flags_q[3] == flags_q[0]);
         4'b1101: cond_ex = flags_q[2] | (flags_q[3] != flags_q[0]);
         4'b1110: cond_ex = 1'b1;
         default: cond_ex = 1'b0;
      endcase
   end

   // Unrecognised commands fall back to ADD and never touch the flags
   always_comb begin
      alu_control = 2'b00;
      cmd_known   = 1'b0;
      cmd_arith   = 1'b0;
      if (alu_op) begin
         case (funct[4:1])
            4'b0100: begin alu_control = 2'b00; cmd_known = 1'b1; cmd_arith = 1'b1; end
            4'b0010: begin alu_control = 2'b01; cmd_known = 1'b1; cmd_arith = 1'b1; end
            4'b0000: begin alu_control = 2'b10; cmd_known = 1'b1; end
            4'b1100: begin alu_control = 2'b11; cmd_known = 1'b1; end
            default: alu_control = 2'b00;
         endcase
      end
   end

   assign flags_we  = ((state == S_EXEC_R) || (state == S_EXEC_I)) &&
                      funct[0] && cond_ex && cmd_known;
   assign reg_write = reg_w & cond_ex;
   assign mem_write = mem_w & cond_ex;
   assign pc_write  = next_pc | (cond_ex & (branch | (reg_w & (rd == 4'hF))));

   always_comb begin
      state_next = S_FETCH;
      adr_src    = 1'b0;
      ir_write   = 1'b0;
      result_src = 2'b00;
      alu_src_a  = 1'b0;
      alu_src_b  = 2'b00;
      reg_w      = 1'b0;
      mem_w      = 1'b0;
      next_pc    = 1'b0;
      branch     = 1'b0;
      alu_op     = 1'b0;
      case (state)
         S_FETCH: begin
            alu_src_a  = 1'b1;
            alu_src_b  = 2'b10;
            result_src = 2'b10;
            ir_write   = 1'b1;
            next_pc    = 1'b1;
            state_next = S_DECODE;
         end
         S_DECODE: begin
            alu_src_a  = 1'b1;
            alu_src_b  = 2'b10;
            result_src = 2'b10;
            case (op)
               2'b00:   state_next = funct[5] ? S_EXEC_I : S_EXEC_R;
               2'b01:   state_next = S_MEM_ADR;
               2'b10:   state_next = S_BRANCH;
               default: state_next = S_FETCH;
            endcase
         end
         S_MEM_ADR: begin
            alu_src_b  = 2'b01;
            state_next = funct[0] ? S_MEM_READ : S_MEM_WRITE;
         end
         S_MEM_READ: begin
            adr_src    = 1'b1;
            state_next = S_MEM_WB;
         end
         S_MEM_WB: begin
            result_src = 2'b01;
            reg_w      = 1'b1;
         end
         S_MEM_WRITE: begin
            adr_src = 1'b1;
            mem_w   = 1'b1;
         end
         S_EXEC_R: begin
            alu_op     = 1'b1;
            state_next = S_ALU_WB;
         end
         S_EXEC_I: begin
            alu_src_b  = 2'b01;
            alu_op     = 1'b1;
            state_next = S_ALU_WB;
         end
         S_ALU_WB: reg_w = 1'b1;
         S_BRANCH: begin
            alu_src_b  = 2'b01;
            result_src = 2'b10;
            branch     = 1'b1;
         end
         default: state_next = S_FETCH;
      endcase
   end

endmodule

// File: tb/tb_multicycle_control_unit.sv
// Directed bench for multicycle_control_unit: per-cycle expected output vectors
// are queued by the driver and compared by a negedge monitor.
module tb_multicycle_control_unit;

   localparam int ST_FETCH = 0, ST_DECODE = 1, ST_MEM_ADR = 2, ST_MEM_READ = 3,
                  ST_MEM_WB = 4, ST_MEM_WRITE = 5, ST_EXEC_R = 6, ST_EXEC_I = 7,
                  ST_ALU_WB = 8, ST_BRANCH = 9;

   logic       clk = 1'b0;
   logic       reset;
   logic [3:0] cond;
   logic [1:0] op;
   logic [5:0] funct;
   logic [3:0] rd;
   logic [3:0] alu_flags;
   logic       pc_write, adr_src, mem_write, ir_write, reg_write, alu_src_a;
   logic [1:0] result_src, alu_src_b, alu_control, imm_src, reg_src;
   logic [3:0] flags;

   logic [19:0] exp_q[$];
   string       name_q[$];
   int          checks = 0;
   int          errors = 0;

   multicycle_control_unit #(.FLAGS_RESET(4'b0000)) dut (
      .clk(clk), .reset(reset), .cond(cond), .op(op), .funct(funct), .rd(rd),
      .alu_flags(alu_flags), .pc_write(pc_write), .adr_src(adr_src),
      .mem_write(mem_write), .ir_write(ir_write), .reg_write(reg_write),
      .result_src(result_src), .alu_src_a(alu_src_a), .alu_src_b(alu_src_b),
      .alu_control(alu_control), .imm_src(imm_src), .reg_src(reg_src), .flags(flags)
   );

   // clock / reset
   always #5 clk = ~clk;

   wire [19:0] got = {pc_write, adr_src, mem_write, ir_write, reg_write, result_src,
                      alu_src_a, alu_src_b, alu_control, imm_src, reg_src, flags};

   // Expected vector: per-state selects from the state table, strobes/ALU/flags hand-supplied.
   function automatic logic [19:0] ev(input int st, input logic pcw, input logic mw,
                                      input logic rw, input logic [1:0] aluc,
                                      input logic [3:0] fl);
      logic       adr, irw, asa;
      logic [1:0] rs, asb;
      adr = 1'b0; irw = 1'b0; asa = 1'b0; rs = 2'b00; asb = 2'b00;
      case (st)
         ST_FETCH:     begin irw = 1'b1; asa = 1'b1; rs = 2'b10; asb = 2'b10; end
         ST_DECODE:    begin asa = 1'b1; rs = 2'b10; asb = 2'b10; end
         ST_MEM_ADR:   asb = 2'b01;
         ST_MEM_READ:  adr = 1'b1;
         ST_MEM_WB:    rs = 2'b01;
         ST_MEM_WRITE: adr = 1'b1;
         ST_EXEC_I:    asb = 2'b01;
         ST_BRANCH:    begin rs = 2'b10; asb = 2'b01; end
         default:      ;
      endcase
      return {pcw, adr, mw, irw, rw, rs, asa, asb, aluc, op, (op == 2'b01), (op == 2'b10), fl};
   endfunction

   // driver tasks
   task automatic set_instr(input logic [31:0] w);
      cond  = w[31:28];
      op    = w[27:26];
      funct = w[25:20];
      rd    = w[15:12];
   endtask

   task automatic cyc(input string nm, input logic [19:0] e);
      exp_q.push_back(e);
      name_q.push_back(nm);
      @(posedge clk);
      #1;
   endtask

   // scoreboard monitor
   always @(negedge clk) begin
      if (exp_q.size() != 0) begin
         logic [19:0] e;
         string       nm;
         e  = exp_q.pop_front();
         nm = name_q.pop_front();
         checks++;
         if (got !== e) begin
            errors++;
            $display("FAIL %s got=%05h exp=%05h", nm, got, e);
         end
      end
   end

   initial begin
      reset = 1'b1;
      alu_flags = 4'b0000;
      set_instr(32'h0);
      repeat (2) @(posedge clk);
      #1;
      reset = 1'b0;

      // ADD R1,R1,#5 : no flag write even with live alu_flags
      set_instr(32'hE2811005);
      alu_flags = 4'b1111;
      cyc("add_i.fetch",  ev(ST_FETCH,  1, 0, 0, 2'b00, 4'b0000));
      cyc("add_i.decode", ev(ST_DECODE, 0, 0, 0, 2'b00, 4'b0000));
      cyc("add_i.exec",   ev(ST_EXEC_I, 0, 0, 0, 2'b00, 4'b0000));
      cyc("add_i.wb",     ev(ST_ALU_WB, 0, 0, 1, 2'b00, 4'b0000));

      // SUBS R2,R1,R2 : flags take alu_flags leaving EXEC_R
      set_instr(32'hE0512002);
      alu_flags = 4'b0100;
      cyc("subs.fetch",  ev(ST_FETCH,  1, 0, 0, 2'b00, 4'b0000));
      cyc("subs.decode", ev(ST_DECODE, 0, 0, 0, 2'b00, 4'b0000));
      cyc("subs.exec",   ev(ST_EXEC_R, 0, 0, 0, 2'b01, 4'b0000));
      alu_flags = 4'b1011;
      cyc("subs.wb",     ev(ST_ALU_WB, 0, 0, 1, 2'b00, 4'b0100));

      // ADDEQ with Z=1 writes
      set_instr(32'h02811005);
      cyc("addeq.fetch", ev(ST_FETCH,  1, 0, 0, 2'b00, 4'b0100));
      cyc("addeq.dec",   ev(ST_DECODE, 0, 0, 0, 2'b00, 4'b0100));
      cyc("addeq.exec",  ev(ST_EXEC_I, 0, 0, 0, 2'b00, 4'b0100));
      cyc("addeq.wb",    ev(ST_ALU_WB, 0, 0, 1, 2'b00, 4'b0100));

      // ADDNE with rd=15 and Z=1: suppressed, sequence unchanged
      set_instr(32'h1281F005);
      cyc("addne.fetch", ev(ST_FETCH,  1, 0, 0, 2'b00, 4'b0100));
      cyc("addne.dec",   ev(ST_DECODE, 0, 0, 0, 2'b00, 4'b0100));
      cyc("addne.exec",  ev(ST_EXEC_I, 0, 0, 0, 2'b00, 4'b0100));
      cyc("addne.wb",    ev(ST_ALU_WB, 0, 0, 0, 2'b00, 4'b0100));

      // ADD PC,R1,#5 writes PC in ALU_WB
      set_instr(32'hE281F005);
      cyc("addpc.fetch", ev(ST_FETCH,  1, 0, 0, 2'b00, 4'b0100));
      cyc("addpc.dec",   ev(ST_DECODE, 0, 0, 0, 2'b00, 4'b0100));
      cyc("addpc.exec",  ev(ST_EXEC_I, 0, 0, 0, 2'b00, 4'b0100));
      cyc("addpc.wb",    ev(ST_ALU_WB, 1, 0, 1, 2'b00, 4'b0100));

      // LDR R0,[R1,#4]
      set_instr(32'hE5910004);
      cyc("ldr.fetch", ev(ST_FETCH,    1, 0, 0, 2'b00, 4'b0100));
      cyc("ldr.dec",   ev(ST_DECODE,   0, 0, 0, 2'b00, 4'b0100));
      cyc("ldr.adr",   ev(ST_MEM_ADR,  0, 0, 0, 2'b00, 4'b0100));
      cyc("ldr.read",  ev(ST_MEM_READ, 0, 0, 0, 2'b00, 4'b0100));
      cyc("ldr.wb",    ev(ST_MEM_WB,   0, 0, 1, 2'b00, 4'b0100));

      // STR R0,[R1,#4]
      set_instr(32'hE5810004);
      cyc("str.fetch", ev(ST_FETCH,     1, 0, 0, 2'b00, 4'b0100));
      cyc("str.dec",   ev(ST_DECODE,    0, 0, 0, 2'b00, 4'b0100));
      cyc("str.adr",   ev(ST_MEM_ADR,   0, 0, 0, 2'b00, 4'b0100));
      cyc("str.write", ev(ST_MEM_WRITE, 0, 1, 0, 2'b00, 4'b0100));

      // B
      set_instr(32'hEA000002);
      cyc("b.fetch",  ev(ST_FETCH,  1, 0, 0, 2'b00, 4'b0100));
      cyc("b.dec",    ev(ST_DECODE, 0, 0, 0, 2'b00, 4'b0100));
      cyc("b.branch", ev(ST_BRANCH, 1, 0, 0, 2'b00, 4'b0100));

      // ORRS: N,Z from ALU, C,V held
      set_instr(32'hE1912002);
      alu_flags = 4'b1011;
      cyc("orrs.fetch", ev(ST_FETCH,  1, 0, 0, 2'b00, 4'b0100));
      cyc("orrs.dec",   ev(ST_DECODE, 0, 0, 0, 2'b00, 4'b0100));
      cyc("orrs.exec",  ev(ST_EXEC_R, 0, 0, 0, 2'b11, 4'b0100));
      cyc("orrs.wb",    ev(ST_ALU_WB, 0, 0, 1, 2'b00, 4'b1000));

      // Unknown cmd with S: ADD, no flag write, rd still written
      set_instr(32'hE1512002);
      alu_flags = 4'b0111;
      cyc("cmp.fetch", ev(ST_FETCH,  1, 0, 0, 2'b00, 4'b1000));
      cyc("cmp.dec",   ev(ST_DECODE, 0, 0, 0, 2'b00, 4'b1000));
      cyc("cmp.exec",  ev(ST_EXEC_R, 0, 0, 0, 2'b00, 4'b1000));
      cyc("cmp.wb",    ev(ST_ALU_WB, 0, 0, 1, 2'b00, 4'b1000));

      // SUBSEQ with Z=0: no write, no flag update
      set_instr(32'h00512002);
      alu_flags = 4'b1111;
      cyc("subseq.fetch", ev(ST_FETCH,  1, 0, 0, 2'b00, 4'b1000));
      cyc("subseq.dec",   ev(ST_DECODE, 0, 0, 0, 2'b00, 4'b1000));
      cyc("subseq.exec",  ev(ST_EXEC_R, 0, 0, 0, 2'b01, 4'b1000));
      cyc("subseq.wb",    ev(ST_ALU_WB, 0, 0, 0, 2'b00, 4'b1000));

      // BEQ with Z=0
      set_instr(32'h0A000002);
      cyc("beq.fetch",  ev(ST_FETCH,  1, 0, 0, 2'b00, 4'b1000));
      cyc("beq.dec",    ev(ST_DECODE, 0, 0, 0, 2'b00, 4'b1000));
      cyc("beq.branch", ev(ST_BRANCH, 0, 0, 0, 2'b00, 4'b1000));

      // Undefined op=11
      set_instr(32'hEC00F000);
      cyc("undef.fetch", ev(ST_FETCH,  1, 0, 0, 2'b00, 4'b1000));
      cyc("undef.dec",   ev(ST_DECODE, 0, 0, 0, 2'b00, 4'b1000));

      // LDR interrupted by reset in MEM_READ
      set_instr(32'hE5910004);
      cyc("rst.fetch", ev(ST_FETCH,    1, 0, 0, 2'b00, 4'b1000));
      cyc("rst.dec",   ev(ST_DECODE,   0, 0, 0, 2'b00, 4'b1000));
      cyc("rst.adr",   ev(ST_MEM_ADR,  0, 0, 0, 2'b00, 4'b1000));
      reset = 1'b1;
      cyc("rst.read",  ev(ST_MEM_READ, 0, 0, 0, 2'b00, 4'b1000));
      reset = 1'b0;
      cyc("rst.after", ev(ST_FETCH,    1, 0, 0, 2'b00, 4'b0000));
      cyc("rst.dec2",  ev(ST_DECODE,   0, 0, 0, 2'b00, 4'b0000));
      cyc("rst.adr2",  ev(ST_MEM_ADR,  0, 0, 0, 2'b00, 4'b0000));

      @(negedge clk);
      checks++;
      if (exp_q.size() != 0) begin
         errors++;
         $display("FAIL drain got=%0d pending exp=0", exp_q.size());
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
